// File: rtl/winograd_feeder_pkg.sv
// Shared constants and types for the Winograd operand feeder.
package winograd_pkg;
  localparam int NUM_LANES  = 8;
  localparam int LANE_IDX_W = $clog2(NUM_LANES);
  // fill count must reach NUM_LANES, so it needs one bit more than a lane index
  localparam int CNT_W      = LANE_IDX_W + 1;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } feeder_state_e;
endpackage

// File: rtl/winograd_feeder_if.sv
// Activation stream, weight write port and operand handshake of the feeder.
interface winograd_feeder_if #(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8
) ();
  import winograd_pkg::*;

  logic                                  w_wr_i;
  logic [LANE_IDX_W-1:0]                 w_idx_i;
  logic [IN_SIZE_0-1:0]                  w_data_i;
  logic                                  w_ready_o;
  logic                                  act_valid_i;
  logic                                  act_ready_o;
  logic [IN_SIZE_1-1:0]                  act_data_i;
  logic                                  act_last_i;
  logic                                  out_valid_o;
  logic                                  out_ready_i;
  logic [NUM_LANES-1:0][IN_SIZE_0-1:0]   in_0_o;
  logic [NUM_LANES-1:0][IN_SIZE_1-1:0]   in_1_o;
  logic                                  busy_o;

  modport master (
    output w_wr_i, w_idx_i, w_data_i, act_valid_i, act_data_i, act_last_i, out_ready_i,
    input  w_ready_o, act_ready_o, out_valid_o, in_0_o, in_1_o, busy_o
  );

  modport slave (
    input  w_wr_i, w_idx_i, w_data_i, act_valid_i, act_data_i, act_last_i, out_ready_i,
    output w_ready_o, act_ready_o, out_valid_o, in_0_o, in_1_o, busy_o
  );
endinterface

// File: rtl/winograd_feeder_act_window.sv
// Activation window buffer: in-order lane writes, shift down by STRIDE, clear.
module winograd_act_window
  import winograd_pkg::*;
#(
  parameter int W      = 8,
  parameter int STRIDE = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_i,
  input  logic [W-1:0]                wr_data_i,
  input  logic                        shift_i,
  input  logic                        clr_i,
  output logic [NUM_LANES-1:0][W-1:0] lanes_o,
  output logic [CNT_W-1:0]            fill_cnt_o
);
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;

  // clear wins over shift, shift over write; the FSM never asserts two at once
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (clr_i)        fill_cnt_d = '0;
    else if (shift_i) fill_cnt_d = CNT_W'(NUM_LANES - STRIDE);
    else if (wr_i)    fill_cnt_d = fill_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fill_cnt_q <= '0;
    else         fill_cnt_q <= fill_cnt_d;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [W-1:0] lane_q;
    logic [W-1:0] shift_val;

    // lanes with no source STRIDE above them are vacated by the shift
    if (i + STRIDE < NUM_LANES) begin : g_src
      assign shift_val = lanes_o[i+STRIDE];
    end else begin : g_zero
      assign shift_val = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                   lane_q <= '0;
      else if (clr_i)                                lane_q <= '0;
      else if (shift_i)                              lane_q <= shift_val;
      else if (wr_i && fill_cnt_q == CNT_W'(i))      lane_q <= wr_data_i;
    end

    assign lanes_o[i] = lane_q;
  end

  assign fill_cnt_o = fill_cnt_q;
endmodule

// File: rtl/winograd_feeder.sv
// Builds strided 8-lane activation windows and presents them with the weight bank.
module winograd_feeder
  import winograd_pkg::*;
#(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  parameter int STRIDE    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  winograd_feeder_if.slave  bus
);
  feeder_state_e state_q, state_d;
  logic          last_seen_q, last_seen_d;
  logic          win_wr, win_shift, win_clr;
  logic          act_ready, out_valid;
  logic [CNT_W-1:0]                    fill_cnt;
  logic [NUM_LANES-1:0][IN_SIZE_1-1:0] lanes;
  logic [NUM_LANES-1:0][IN_SIZE_0-1:0] weights_q;

  winograd_act_window #(
    .W      (IN_SIZE_1),
    .STRIDE (STRIDE)
  ) u_window (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_i       (win_wr),
    .wr_data_i  (bus.act_data_i),
    .shift_i    (win_shift),
    .clr_i      (win_clr),
    .lanes_o    (lanes),
    .fill_cnt_o (fill_cnt)
  );

  always_comb begin
    state_d     = state_q;
    last_seen_d = last_seen_q;
    act_ready   = 1'b0;
    out_valid   = 1'b0;
    win_wr      = 1'b0;
    win_shift   = 1'b0;
    win_clr     = 1'b0;
    unique case (state_q)
      FILL: begin
        act_ready = 1'b1;
        if (bus.act_valid_i) begin
          win_wr = 1'b1;
          if (bus.act_last_i || fill_cnt == CNT_W'(NUM_LANES - 1)) begin
            state_d     = EMIT;
            last_seen_d = bus.act_last_i;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) begin
          state_d = FILL;
          // end of row drops the overlap so the next row starts at lane 0
          if (last_seen_q) begin
            win_clr     = 1'b1;
            last_seen_d = 1'b0;
          end else begin
            win_shift = 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FILL;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_seen_q <= last_seen_d;
    end
  end

  // weights only change while no window is on offer, so in_0_o is stable in EMIT
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             weights_q <= '0;
    else if (bus.w_wr_i && state_q == FILL)  weights_q[bus.w_idx_i] <= bus.w_data_i;
  end

  assign bus.w_ready_o   = (state_q == FILL);
  assign bus.act_ready_o = act_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.in_0_o      = weights_q;
  assign bus.in_1_o      = lanes;
  assign bus.busy_o      = (fill_cnt != '0) || (state_q == EMIT);
endmodule

// File: tb/tb_winograd_feeder.sv
// Directed bench for winograd_feeder: row table plus stall, stride-8 and reset sequences.
module tb_winograd_feeder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  winograd_feeder_if #(.IN_SIZE_0(4), .IN_SIZE_1(8)) bus2 ();
  winograd_feeder_if #(.IN_SIZE_0(4), .IN_SIZE_1(8)) bus8 ();

  winograd_feeder #(.IN_SIZE_0(4), .IN_SIZE_1(8), .STRIDE(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus2));
  winograd_feeder #(.IN_SIZE_0(4), .IN_SIZE_1(8), .STRIDE(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus8));

  typedef struct packed {
    logic [63:0] a;
    logic [31:0] w;
  } win_t;
  win_t q2[$];
  win_t q8[$];

  always @(posedge clk) begin
    if (bus2.out_valid_o && bus2.out_ready_i) q2.push_back('{bus2.in_1_o, bus2.in_0_o});
    if (bus8.out_valid_o && bus8.out_ready_i) q8.push_back('{bus8.in_1_o, bus8.in_0_o});
  end

  typedef struct {
    int base;
    int step;
    int len;
    int nwin;
    int ws[3];
    int wn[3];
  } row_vec_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] wexp;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // window whose first n lanes count from start by step, rest zero
  function automatic logic [63:0] seq(input int start, input int step, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = 8'(start + i * step);
    return r;
  endfunction

  task automatic send(input bit s8, input logic [7:0] d, input logic last);
    int t = 0;
    if (s8) begin
      bus8.act_valid_i = 1'b1; bus8.act_data_i = d; bus8.act_last_i = last;
      while (!bus8.act_ready_o && t < 100) begin @(negedge clk); t++; end
    end else begin
      bus2.act_valid_i = 1'b1; bus2.act_data_i = d; bus2.act_last_i = last;
      while (!bus2.act_ready_o && t < 100) begin @(negedge clk); t++; end
    end
    if (t >= 100) chk("send_timeout", 64'(t), 64'(0));
    @(negedge clk);
    bus2.act_valid_i = 1'b0; bus2.act_last_i = 1'b0;
    bus8.act_valid_i = 1'b0; bus8.act_last_i = 1'b0;
  endtask

  task automatic wait_idle(input bit s8);
    int t = 0;
    while ((s8 ? bus8.busy_o : bus2.busy_o) && t < 60) begin @(negedge clk); t++; end
    chk("idle", 64'(s8 ? bus8.busy_o : bus2.busy_o), 64'(0));
  endtask

  row_vec_t rows[4];
  win_t     wv;

  initial begin
    rows[0] = '{1,   1,  12, 3, '{1, 3, 5},   '{8, 8, 8}};
    rows[1] = '{10,  10, 3,  1, '{10, 0, 0},  '{3, 0, 0}};
    rows[2] = '{40,  1,  8,  1, '{40, 0, 0},  '{8, 0, 0}};
    rows[3] = '{100, 1,  9,  2, '{100, 102, 0}, '{8, 7, 0}};
    for (int i = 0; i < 8; i++) wexp[i*4 +: 4] = 4'(i + 1);

    rst_n = 1'b0;
    bus2.w_wr_i = 0; bus2.w_idx_i = '0; bus2.w_data_i = '0; bus2.act_valid_i = 0;
    bus2.act_data_i = '0; bus2.act_last_i = 0; bus2.out_ready_i = 0;
    bus8.w_wr_i = 0; bus8.w_idx_i = '0; bus8.w_data_i = '0; bus8.act_valid_i = 0;
    bus8.act_data_i = '0; bus8.act_last_i = 0; bus8.out_ready_i = 0;
    repeat (2) @(negedge clk);

    chk("rst_out_valid", 64'(bus2.out_valid_o), 64'(0));
    chk("rst_act_ready", 64'(bus2.act_ready_o), 64'(1));
    chk("rst_w_ready",   64'(bus2.w_ready_o),   64'(1));
    chk("rst_busy",      64'(bus2.busy_o),      64'(0));
    chk("rst_in_1",      bus2.in_1_o,           64'(0));
    chk("rst_in_0",      64'(bus2.in_0_o),      64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // weights and a full row together, last on sample 8
    for (int i = 0; i < 8; i++) begin
      bus2.act_valid_i = 1; bus2.act_data_i = 8'(i + 1); bus2.act_last_i = (i == 7);
      bus2.w_wr_i = 1; bus2.w_idx_i = 3'(i); bus2.w_data_i = 4'(i + 1);
      @(negedge clk);
    end
    bus2.act_valid_i = 0; bus2.act_last_i = 0; bus2.w_wr_i = 0;
    chk("t1_out_valid", 64'(bus2.out_valid_o), 64'(1));
    chk("t1_act_ready", 64'(bus2.act_ready_o), 64'(0));
    chk("t1_w_ready",   64'(bus2.w_ready_o),   64'(0));
    chk("t1_in_1",      bus2.in_1_o,           seq(1, 1, 8));
    chk("t1_in_0",      64'(bus2.in_0_o),      64'(wexp));
    bus2.out_ready_i = 1;
    @(negedge clk);
    chk("t1_post_valid", 64'(bus2.out_valid_o), 64'(0));
    chk("t1_post_ready", 64'(bus2.act_ready_o), 64'(1));
    chk("t1_post_busy",  64'(bus2.busy_o),      64'(0));
    chk("t1_post_in_1",  bus2.in_1_o,           64'(0));

    // row table, out_ready held high
    for (int r = 0; r < 4; r++) begin
      q2.delete();
      for (int k = 0; k < rows[r].len; k++)
        send(0, 8'(rows[r].base + k * rows[r].step), k == rows[r].len - 1);
      wait_idle(0);
      chk($sformatf("row%0d_nwin", r), 64'(q2.size()), 64'(rows[r].nwin));
      for (int k = 0; k < rows[r].nwin && q2.size() > 0; k++) begin
        wv = q2.pop_front();
        chk($sformatf("row%0d_win%0d_act", r, k), wv.a, seq(rows[r].ws[k], rows[r].step, rows[r].wn[k]));
        chk($sformatf("row%0d_win%0d_wt", r, k), 64'(wv.w), 64'(wexp));
      end
    end

    // stall in EMIT with activation and weight traffic
    bus2.out_ready_i = 0;
    for (int k = 0; k < 8; k++) send(0, 8'(k + 1), 1'b0);
    chk("stall_valid", 64'(bus2.out_valid_o), 64'(1));
    for (int c = 0; c < 5; c++) begin
      bus2.act_valid_i = 1; bus2.act_data_i = 8'd99;
      bus2.w_wr_i = 1; bus2.w_idx_i = 3'd0; bus2.w_data_i = 4'd15;
      @(negedge clk);
      chk($sformatf("stall%0d_act_ready", c), 64'(bus2.act_ready_o), 64'(0));
      chk($sformatf("stall%0d_w_ready", c),   64'(bus2.w_ready_o),   64'(0));
      chk($sformatf("stall%0d_in_1", c),      bus2.in_1_o,           seq(1, 1, 8));
      chk($sformatf("stall%0d_in_0", c),      64'(bus2.in_0_o),      64'(wexp));
    end
    bus2.act_valid_i = 0; bus2.w_wr_i = 0; bus2.out_ready_i = 1;
    q2.delete();
    @(negedge clk);
    chk("rel_valid",  64'(bus2.out_valid_o), 64'(0));
    chk("rel_ready",  64'(bus2.act_ready_o), 64'(1));
    chk("rel_in_1",   bus2.in_1_o,           seq(3, 1, 6));
    chk("rel_in_0",   64'(bus2.in_0_o),      64'(wexp));
    chk("rel_nwin",   64'(q2.size()),        64'(1));
    send(0, 8'd9, 1'b1);
    wait_idle(0);
    chk("rel_nwin2",  64'(q2.size()),        64'(2));
    if (q2.size() == 2) chk("rel_last_win", q2[1].a, seq(3, 1, 7));

    // stride 8: non-overlapping tiles
    bus8.out_ready_i = 1;
    for (int k = 0; k < 16; k++) send(1, 8'(k + 1), 1'b0);
    wait_idle(1);
    chk("s8_nwin", 64'(q8.size()), 64'(2));
    if (q8.size() == 2) begin
      chk("s8_win0", q8[0].a, seq(1, 1, 8));
      chk("s8_win1", q8[1].a, seq(9, 1, 8));
      chk("s8_wt",   64'(q8[1].w), 64'(0));
    end

    // reset with a window pending
    bus2.out_ready_i = 0;
    for (int k = 0; k < 8; k++) send(0, 8'(k + 1), 1'b0);
    chk("prerst_valid", 64'(bus2.out_valid_o), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus2.out_valid_o), 64'(0));
    chk("arst_ready", 64'(bus2.act_ready_o), 64'(1));
    chk("arst_busy",  64'(bus2.busy_o),      64'(0));
    chk("arst_in_1",  bus2.in_1_o,           64'(0));
    chk("arst_in_0",  64'(bus2.in_0_o),      64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus2.out_ready_i = 1;
    q2.delete();
    @(negedge clk);
    for (int k = 0; k < 8; k++) send(0, 8'(k + 5), k == 7);
    wait_idle(0);
    chk("post_rst_nwin", 64'(q2.size()), 64'(1));
    if (q2.size() == 1) begin
      chk("post_rst_act", q2[0].a, seq(5, 1, 8));
      chk("post_rst_wt",  64'(q2[0].w), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
